rng_seed_ctrl: RTL

Sequencer and arbiter for the 16-bit seeded random source in the 2D RNG design.
- Loads the 16-bit seed into an internal Fibonacci LFSR and runs a programmable warm-up.
- Then shares the generator between two requesters (X and Y coordinate consumers) with a round-robin req/gnt handshake.
- Supports on-demand reseeding at any time.

---
 rtl/rng_seed_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/rng_seed_ctrl.sv
// rng_seed_ctrl: seeds and warms a 16-bit Fibonacci LFSR, then serves two
// requesters round-robin, one word per grant, with reseed available at any time.
module rng_seed_ctrl #(
  parameter int          WARMUP   = 16,
  parameter logic [15:0] ZERO_SUB = 16'hACE1
) (
  input  logic        CLK500Hz,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic        reseed,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [15:0] rnd,
  output logic        rnd_valid,
  output logic        ready
);
  typedef enum logic [1:0] {LOAD, WARM, RUN} state_t;
  localparam logic [7:0] W_LAST = 8'(WARMUP - 1);
  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [7:0]  r_cnt;
  logic        r_ptr;
  logic [15:0] w_next;
  logic        w_pick;
  assign w_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // only a genuine tie consults the round-robin pointer
  assign w_pick = (req == 2'b11) ? r_ptr : req[1];
  always_ff @(posedge CLK500Hz or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD;
      r_lfsr    <= '0;
      r_cnt     <= '0;
      r_ptr     <= 1'b0;
      gnt       <= 2'b00;
      rnd       <= '0;
      rnd_valid <= 1'b0;
      ready     <= 1'b0;
    end else begin
      gnt       <= 2'b00;
      rnd_valid <= 1'b0;
      if (reseed) begin
        r_state <= LOAD;
        ready   <= 1'b0;
      end else begin
        case (r_state)
          LOAD: begin
            r_lfsr  <= (seed == '0) ? ZERO_SUB : seed;
            r_cnt   <= '0;
            r_state <= (WARMUP > 0) ? WARM : RUN;
            ready   <= (WARMUP == 0);
          end
          WARM: begin
            r_lfsr <= w_next;
            r_cnt  <= r_cnt + 8'd1;
            if (r_cnt == W_LAST) begin
              r_state <= RUN;
              ready   <= 1'b1;
            end
          end
          RUN: begin
            if (|req) begin
              gnt       <= w_pick ? 2'b10 : 2'b01;
              rnd       <= r_lfsr;
              rnd_valid <= 1'b1;
              r_lfsr    <= w_next;
              r_ptr     <= ~w_pick;
            end
          end
          default: r_state <= LOAD;
        endcase
      end
    end
  end
endmodule
